// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states,
// byte-lane strobe constants and request legality checks.
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } load_f3_e;

  typedef enum logic [2:0] {
    SB = 3'd0,
    SH = 3'd1,
    SW = 3'd2
  } store_f3_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_RD,
    WAIT_RD,
    ISSUE_WR,
    FAULT,
    RSP
  } state_e;

  localparam logic [3:0] BYTE_STRB = 4'b0001;
  localparam logic [3:0] HALF_STRB = 4'b0011;
  localparam logic [3:0] WORD_STRB = 4'b1111;

  // Loads reserve 3/6/7; stores only define 0..2.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3 > 3'd2;
    else    return (f3 == 3'd3) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: shifts the addressed byte/halfword down to bit 0 and
// sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    result  = '0;
    case (funct3)
      LB:      result = {{24{shifted[7]}}, shifted[7:0]};
      LH:      result = {{16{shifted[15]}}, shifted[15:0]};
      LW:      result = shifted;
      LBU:     result = {24'h0, shifted[7:0]};
      LHU:     result = {16'h0, shifted[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding request, registered RAM strobes and a
// single-cycle response pulse. Optional perf counters under LSU_PERF_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int AddrBusWidth = 32,
  parameter int DataBusWidth = 32  // only 32 (four byte lanes) is supported
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [AddrBusWidth-1:0] req_addr,
  input  logic [DataBusWidth-1:0] req_wdata,
  input  logic [2:0]              req_funct3,
  output logic                    rsp_valid,
  output logic [DataBusWidth-1:0] rsp_rdata,
  output logic                    rsp_misaligned,
  output logic                    rsp_illegal,
  output logic                    mem_re,
  output logic [AddrBusWidth-1:0] mem_r_addr,
  output logic                    mem_we,
  output logic [AddrBusWidth-1:0] mem_w_addr,
  output logic [DataBusWidth-1:0] mem_w_data,
  output logic [DataBusWidth-1:0] mem_w_size,
  input  logic [DataBusWidth-1:0] mem_r_data
`ifdef LSU_PERF_EN
  ,
  output logic [31:0]             perf_loads,
  output logic [31:0]             perf_stores,
  output logic [31:0]             perf_faults
`endif
);

  state_e                  state, n_state;
  logic [1:0]              off_q, n_off;
  logic [2:0]              f3_q, n_f3;
  logic                    n_mem_re, n_mem_we, n_rsp_valid, n_mis, n_ill;
  logic                    ill, mis;
  logic [AddrBusWidth-1:0] n_r_addr, n_w_addr;
  logic [DataBusWidth-1:0] n_w_data, n_w_size, n_rsp_rdata;
  logic [31:0]             load_data;

  // In reset the state register is IDLE, so rst gates ready low explicitly.
  assign req_ready = rst && (state == IDLE);

  lsu_load_align u_align (
    .word   (mem_r_data),
    .offset (off_q),
    .funct3 (f3_q),
    .result (load_data)
  );

  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path leaves a value held (no latches).
    n_state     = state;
    n_off       = off_q;
    n_f3        = f3_q;
    n_mem_re    = 1'b0;
    n_mem_we    = 1'b0;
    n_r_addr    = '0;
    n_w_addr    = '0;
    n_w_data    = '0;
    n_w_size    = '0;
    n_rsp_valid = 1'b0;
    n_rsp_rdata = '0;
    n_mis       = 1'b0;
    n_ill       = 1'b0;
    ill         = f3_illegal(req_we, req_funct3);
    mis         = !ill && addr_misaligned(req_funct3, req_addr[1:0]);

    case (state)
      IDLE: if (req_valid) begin
        n_off = req_addr[1:0];
        n_f3  = req_funct3;
        if (ill || mis) begin
          n_state     = FAULT;
          n_rsp_valid = 1'b1;
          n_ill       = ill;
          n_mis       = mis;
        end else if (req_we) begin
          n_state  = ISSUE_WR;
          n_mem_we = 1'b1;
          n_w_addr = req_addr >> 2;
          case (req_funct3)
            SB: begin
              n_w_size[3:0] = BYTE_STRB << req_addr[1:0];
              n_w_data      = {{(DataBusWidth-8){1'b0}}, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
            end
            SH: begin
              n_w_size[3:0] = HALF_STRB << req_addr[1:0];
              n_w_data      = {{(DataBusWidth-16){1'b0}}, req_wdata[15:0]} << {req_addr[1:0], 3'b000};
            end
            default: begin
              n_w_size[3:0] = WORD_STRB;
              n_w_data      = req_wdata;
            end
          endcase
        end else begin
          n_state  = ISSUE_RD;
          n_mem_re = 1'b1;
          n_r_addr = {req_addr[AddrBusWidth-1:2], 2'b00};
        end
      end
      ISSUE_RD: n_state = WAIT_RD;
      WAIT_RD: begin
        n_state     = RSP;
        n_rsp_valid = 1'b1;
        n_rsp_rdata = load_data;
      end
      ISSUE_WR: begin
        n_state     = RSP;
        n_rsp_valid = 1'b1;
      end
      default: n_state = IDLE;  // FAULT and RSP both hold the response for one cycle
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      off_q          <= '0;
      f3_q           <= '0;
      mem_re         <= 1'b0;
      mem_we         <= 1'b0;
      mem_r_addr     <= '0;
      mem_w_addr     <= '0;
      mem_w_data     <= '0;
      mem_w_size     <= '0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_misaligned <= 1'b0;
      rsp_illegal    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state          <= n_state;
      off_q          <= n_off;
      f3_q           <= n_f3;
      mem_re         <= n_mem_re;
      mem_we         <= n_mem_we;
      mem_r_addr     <= n_r_addr;
      mem_w_addr     <= n_w_addr;
      mem_w_data     <= n_w_data;
      mem_w_size     <= n_w_size;
      rsp_valid      <= n_rsp_valid;
      rsp_rdata      <= n_rsp_rdata;
      rsp_misaligned <= n_mis;
      rsp_illegal    <= n_ill;
    end
  end

`ifdef LSU_PERF_EN
  logic we_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q        <= 1'b0;
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_faults <= '0;
    end else begin
      if (state == IDLE && req_valid) we_q <= req_we;
      if (rsp_valid) begin
        if (rsp_misaligned || rsp_illegal) perf_faults <= perf_faults + 32'd1;
        else if (we_q)                     perf_stores <= perf_stores + 32'd1;
        else                               perf_loads  <= perf_loads + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small behavioural data RAM attached to the memory port.
module tb_lsu;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_misaligned, rsp_illegal;
  logic [31:0] rsp_rdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_r_addr, mem_w_addr, mem_w_data, mem_w_size, mem_r_data;
`ifdef LSU_PERF_EN
  logic [31:0] perf_loads, perf_stores, perf_faults;
`endif

  int total = 0;
  int bad   = 0;

  lsu dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_funct3     (req_funct3),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_misaligned (rsp_misaligned),
    .rsp_illegal    (rsp_illegal),
    .mem_re         (mem_re),
    .mem_r_addr     (mem_r_addr),
    .mem_we         (mem_we),
    .mem_w_addr     (mem_w_addr),
    .mem_w_data     (mem_w_data),
    .mem_w_size     (mem_w_size),
    .mem_r_data     (mem_r_data)
`ifdef LSU_PERF_EN
    ,
    .perf_loads     (perf_loads),
    .perf_stores    (perf_stores),
    .perf_faults    (perf_faults)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-indexed RAM; read data appears the cycle after mem_re is sampled.
  logic [31:0] ram [0:255];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    mem_r_data = 32'h0;
  end
  always @(posedge clk) begin
    if (mem_re) mem_r_data <= ram[mem_r_addr[9:2]];
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_w_size[i]) ram[mem_w_addr[7:0]][8*i +: 8] <= mem_w_data[8*i +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          re_n, we_n, re_cyc, we_cyc, rsp_cyc;
  logic [31:0] r_addr_s, w_addr_s, w_data_s, w_size_s, rdata_s;
  logic [1:0]  flags_s;
  logic        ready_before, ready_rsp, ready_after, quiet_bad;

  // Issues one request and records what the DUT does in each cycle after acceptance.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
    re_n = 0; we_n = 0; re_cyc = 0; we_cyc = 0; rsp_cyc = 0;
    r_addr_s = 0; w_addr_s = 0; w_data_s = 0; w_size_s = 0; rdata_s = 32'hFFFF_FFFF;
    flags_s = 2'b11; ready_rsp = 1'b1; quiet_bad = 1'b0;
    @(negedge clk);
    ready_before = req_ready;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (mem_re) begin re_n++; re_cyc = cyc; r_addr_s = mem_r_addr; end
      if (mem_we) begin
        we_n++; we_cyc = cyc;
        w_addr_s = mem_w_addr; w_data_s = mem_w_data; w_size_s = mem_w_size;
      end
      if (rsp_valid) begin
        rsp_cyc = cyc; rdata_s = rsp_rdata;
        flags_s = {rsp_misaligned, rsp_illegal}; ready_rsp = req_ready;
        break;
      end
      if (rsp_rdata != 32'h0 || rsp_misaligned || rsp_illegal) quiet_bad = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    ready_after = req_ready;
  endtask

  task automatic common_checks(input string tag, input int lat);
    check({tag, ":ready_in"}, ready_before, 1);
    check({tag, ":latency"}, rsp_cyc, lat);
    check({tag, ":ready_rsp"}, ready_rsp, 0);
    check({tag, ":ready_after"}, ready_after, 1);
    check({tag, ":quiet"}, quiet_bad, 0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] exp_size,
                          input logic [31:0] exp_data);
    run_req(1'b1, f3, addr, wdata);
    common_checks(tag, 2);
    check({tag, ":we_cyc"}, we_cyc, 1);
    check({tag, ":strobes"}, {re_n[15:0], we_n[15:0]}, 32'h0000_0001);
    check({tag, ":w_addr"}, w_addr_s, addr >> 2);
    check({tag, ":w_size"}, w_size_s, {28'h0, exp_size});
    check({tag, ":w_data"}, w_data_s, exp_data);
    check({tag, ":rdata"}, rdata_s, 0);
    check({tag, ":flags"}, flags_s, 0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp);
    run_req(1'b0, f3, addr, 32'h0);
    common_checks(tag, 3);
    check({tag, ":re_cyc"}, re_cyc, 1);
    check({tag, ":strobes"}, {re_n[15:0], we_n[15:0]}, 32'h0001_0000);
    check({tag, ":r_addr"}, r_addr_s, addr & 32'hFFFF_FFFC);
    check({tag, ":rdata"}, rdata_s, exp);
    check({tag, ":flags"}, flags_s, 0);
  endtask

  task automatic do_fault(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic exp_mis, input logic exp_ill);
    run_req(we, f3, addr, 32'hFFFF_FFFF);
    common_checks(tag, 1);
    check({tag, ":strobes"}, {re_n[15:0], we_n[15:0]}, 0);
    check({tag, ":rdata"}, rdata_s, 0);
    check({tag, ":flags"}, flags_s, {exp_mis, exp_ill});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic seen;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'd0;
    repeat (2) @(negedge clk);
    check("reset:ctl", {26'h0, req_ready, rsp_valid, mem_re, mem_we, rsp_misaligned, rsp_illegal}, 0);
    check("reset:data", mem_r_addr | mem_w_addr | mem_w_data | mem_w_size | rsp_rdata, 0);
    rst = 1'b1;
    #1 check("reset:ready_release", req_ready, 1);

    do_store("sw100", 3'd2, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF);
    do_store("sb103", 3'd0, 32'h103, 32'h0000_00A5, 4'h8, 32'hA500_0000);
    check("ram_after_sb", ram[8'h40], 32'hA5AD_BEEF);
    do_load("lb103",  3'd0, 32'h103, 32'hFFFF_FFA5);
    do_load("lbu103", 3'd4, 32'h103, 32'h0000_00A5);
    do_load("lh102",  3'd1, 32'h102, 32'hFFFF_A5AD);
    do_load("lhu102", 3'd5, 32'h102, 32'h0000_A5AD);
    do_load("lw100",  3'd2, 32'h100, 32'hA5AD_BEEF);
    do_load("lb101",  3'd0, 32'h101, 32'hFFFF_FFBE);
    do_store("sh102", 3'd1, 32'h102, 32'hFFFF_1234, 4'hC, 32'h1234_0000);
    do_load("lw100b", 3'd2, 32'h100, 32'h1234_BEEF);
    do_fault("lw102_mis",  1'b0, 3'd2, 32'h102, 1'b1, 1'b0);
    do_fault("ld_f3_ill",  1'b0, 3'd3, 32'h100, 1'b0, 1'b1);
    do_fault("st_f5_ill",  1'b1, 3'd5, 32'h101, 1'b0, 1'b1);
    do_fault("lh101_mis",  1'b0, 3'd1, 32'h101, 1'b1, 1'b0);
`ifdef LSU_PERF_EN
    check("perf_loads",  perf_loads,  7);
    check("perf_stores", perf_stores, 3);
    check("perf_faults", perf_faults, 4);
`endif

    // Reset while the load waits for RAM data: everything clears, no response follows.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid:issue_re", mem_re, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid:ctl", {26'h0, req_ready, rsp_valid, mem_re, mem_we, rsp_misaligned, rsp_illegal}, 0);
    check("rst_mid:data", mem_r_addr | mem_w_addr | mem_w_data | mem_w_size | rsp_rdata, 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || mem_re || mem_we) seen = 1'b1;
    end
    check("rst_mid:silent", seen, 0);
`ifdef LSU_PERF_EN
    check("rst_mid:perf_clr", perf_loads | perf_stores | perf_faults, 0);
`endif
    rst = 1'b1;
    #1 check("rst_mid:ready", req_ready, 1);
    do_load("lw_after_rst", 3'd2, 32'h100, 32'h1234_BEEF);
`ifdef LSU_PERF_EN
    check("perf_loads_after_rst", perf_loads, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit: the initiator side of the core's data-RAM port. Accepts one CPU load/store request at a time over a valid/ready handshake. Drives the RAM's read/write strobes, addresses, write data and byte-lane strobes. Captures RAM read data, aligns and sign/zero-extends it, and returns a single-cycle response pulse. Sits between the execute stage and the data RAM.

Parameters:
AddrBusWidth, 32, address width of request and memory ports
DataBusWidth, 32, data width; only 32 is supported (4 byte lanes)

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  reset, asynchronous, active-low (0 = in reset)
req_valid  in  1  request present
req_ready  out  1  LSU can accept; 1 iff state IDLE and rst=1
req_we  in  1  1 = store, 0 = load
req_addr  in  AddrBusWidth  byte address
req_wdata  in  DataBusWidth  store data, right-aligned
req_funct3  in  3  RV32 funct3: load 0/1/2/4/5, store 0/1/2
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DataBusWidth  extended load data; 0 for stores and faults
rsp_misaligned  out  1  valid with rsp_valid: address misaligned
rsp_illegal  out  1  valid with rsp_valid: unsupported funct3
mem_re  out  1  RAM read enable
mem_r_addr  out  AddrBusWidth  read byte address, bits[1:0] forced 0
mem_we  out  1  RAM write enable
mem_w_addr  out  AddrBusWidth  write word index = req_addr>>2
mem_w_data  out  DataBusWidth  lane-shifted store data
mem_w_size  out  DataBusWidth  byte strobe in bits[3:0]; bits[31:4] always 0
mem_r_data  in  DataBusWidth  RAM read data, valid the cycle after the edge that samples mem_re=1

Behaviour:
- All outputs are registered. In reset, every output is 0 and the state is IDLE.
- Accept on a posedge with req_valid && req_ready. Request fields are latched into registers.
- FSM states:
  - IDLE: waits for an accepted request, then moves to ISSUE_RD, ISSUE_WR or FAULT.
  - ISSUE_RD: mem_re=1 for exactly this cycle; next state WAIT_RD.
  - WAIT_RD: at the end of this cycle, mem_r_data is captured, aligned and driven out; rsp_valid=1 in the following cycle; next state IDLE.
  - ISSUE_WR: mem_we=1 for exactly this cycle; next state is the response cycle (rsp_valid=1), then IDLE.
  - FAULT: no memory strobe; rsp_valid=1 with a flag set; then IDLE.
- Latency from accept edge to rsp_valid high: load 3 cycles, store 2, fault 1. No back-to-back acceptance: req_ready returns high in the cycle after rsp_valid.
- Misalignment:
  - Halfword (funct3[1:0]=01) with addr[0]=1.
  - Word (10) with addr[1:0]≠0.
  - Misalignment sets rsp_misaligned.
- Illegal funct3 sets rsp_illegal; illegal takes precedence over misaligned. Illegal encodings: loads 3/6/7; stores ≥3.
- Store lanes, with off=addr[1:0]:
  - Byte: strobe 4'b0001<<off, data req_wdata[7:0]<<8*off.
  - Half: strobe 4'b0011<<off, data req_wdata[15:0]<<8*off.
  - Word: strobe 4'b1111, data req_wdata.
  - Unselected lanes of mem_w_data are 0.
- Load extract: shifted = mem_r_data>>8*off.
  - LB: sign-extend shifted[7:0]; LBU: zero-extend it.
  - LH: sign-extend shifted[15:0]; LHU: zero-extend it.
  - LW: shifted unchanged.
- rsp_rdata, rsp_misaligned and rsp_illegal are 0 whenever rsp_valid=0.
- Reset asserted mid-operation (any state) clears everything immediately; the in-flight access is abandoned and no response is produced. mem_re/mem_we drop asynchronously.

Optional Feature:
LSU_PERF_EN
- Defined: adds 32-bit outputs perf_loads, perf_stores, perf_faults. Each increments on its response pulse, wraps at 2^32, and is cleared by reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package lsu_pkg:
  - funct3 enum (LB, LH, LW, LBU, LHU; SB, SH, SW).
  - FSM state enum.
  - Lane-strobe constants (BYTE_STRB=4'b0001, HALF_STRB=4'b0011, WORD_STRB=4'b1111).
- Sub-module lsu_load_align: combinational; inputs word, offset, funct3; output is the extended 32-bit result.

Test Plan:
1. SW addr 0x100 data 0xDEADBEEF -> mem_we pulse 1 cycle after accept, mem_w_addr=0x40, mem_w_size=0xF, mem_w_data=0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_rdata=0.
2. SB addr 0x103 data 0x000000A5 -> mem_w_size=0x8, mem_w_data=0xA5000000, mem_w_addr=0x40; RAM word becomes 0xA5ADBEEF.
3. LB 0x103 with word 0xA5ADBEEF -> mem_r_addr=0x100, rsp_rdata=0xFFFFFFA5 3 cycles after accept; LBU -> 0x000000A5.
4. LH 0x102 -> 0xFFFFA5AD; LHU 0x102 -> 0x0000A5AD; LW 0x100 -> 0xA5ADBEEF.
5. LW 0x102 -> rsp_valid 1 cycle after accept with rsp_misaligned=1, rsp_rdata=0, no mem_re; funct3=3 load -> rsp_illegal=1, rsp_misaligned=0.
6. rst=0 during WAIT_RD -> all outputs 0 at once, no rsp_valid; after rst=1, req_ready=1 and the next LW 0x100 completes normally.
